gppcu_instr_dispatcher: RTL

GPPCU_INSTR_DISPATCHER -- requirements
Module: gppcu_instr_dispatcher

---
 rtl/gppcu_instr_dispatcher.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gppcu_instr_dispatcher.sv
// Instruction dispatcher: prefetches a program from instruction memory into a small FIFO and streams it to the core.
// Optional GPPCU_DISPATCH_ABORT_EN adds iABORT to cancel a running program.
module gppcu_instr_dispatcher #(
    parameter int DBW    = 32,
    parameter int IBW    = 10,
    parameter int FDEPTH = 4
) (
    input  logic           iACLK,
    input  logic           iRST,
    input  logic           iSTART,
    input  logic [IBW-1:0] iBASE_ADDR,
    input  logic [IBW:0]   iCOUNT,
`ifdef GPPCU_DISPATCH_ABORT_EN
    input  logic           iABORT,
`endif
    output logic           oBUSY,
    output logic           oDONE,
    output logic [IBW-1:0] oIMEM_ADDR,
    output logic           oIMEM_RD,
    input  logic [DBW-1:0] iIMEM_RDATA,
    output logic [DBW-1:0] oINSTR,
    output logic           oINSTR_VALID,
    input  logic           iINSTR_READY
);

    localparam int AW = $clog2(FDEPTH);
    localparam logic [AW+1:0] DEPTH_L = (AW+2)'(FDEPTH);
    localparam logic [AW:0]   OCC_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [IBW:0]  ISS_ONE = (IBW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state;
    state_t         state_n;
    logic [IBW:0]   count_q;
    logic [IBW:0]   cnt_n;
    logic [IBW:0]   issued;
    logic [IBW:0]   issued_n;
    logic           rd_pending;
    logic           rd_n;
    logic [AW:0]    occ;
    logic [AW:0]    occ_n;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_ptr_n;
    logic [AW-1:0]  wr_ptr;
    logic [DBW-1:0] mem [FDEPTH];
    logic [DBW-1:0] head_n;
    logic           push;
    logic           pop;
    logic           abort_req;

`ifdef GPPCU_DISPATCH_ABORT_EN
    assign abort_req = iABORT && ((state == RUN) || (state == DRAIN));
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        pop   = (occ != '0) && iINSTR_READY;
        push  = rd_pending;
        occ_n = occ;
        if (push && !pop)
            occ_n = occ + OCC_ONE;
        else if (!push && pop)
            occ_n = occ - OCC_ONE;
        if (abort_req)
            occ_n = '0;

        // The head register takes the arriving word directly when nothing older remains behind it.
        rd_ptr_n = pop ? rd_ptr + PTR_ONE : rd_ptr;
        head_n   = oINSTR;
        if (occ_n != '0) begin
            if ((occ == '0) || ((occ == OCC_ONE) && pop))
                head_n = iIMEM_RDATA;
            else
                head_n = mem[rd_ptr_n];
        end

        cnt_n    = count_q;
        issued_n = oIMEM_RD ? issued + ISS_ONE : issued;
        state_n  = state;
        case (state)
            IDLE: begin
                if (iSTART) begin
                    cnt_n    = iCOUNT;
                    issued_n = '0;
                    state_n  = (iCOUNT == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issued_n == count_q)
                    state_n = DRAIN;
            end
            DRAIN: begin
                if ((occ_n == '0) && !rd_pending)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort_req)
            state_n = DONE;

        // Next-cycle read is allowed only if its data plus the read now in flight still fit.
        rd_n = (state_n == RUN) && (issued_n < cnt_n) &&
               (({1'b0, occ_n} + (AW+2)'(oIMEM_RD)) < DEPTH_L);
    end

    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            state        <= IDLE;
            count_q      <= '0;
            issued       <= '0;
            rd_pending   <= 1'b0;
            occ          <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            oBUSY        <= 1'b0;
            oDONE        <= 1'b0;
            oIMEM_RD     <= 1'b0;
            oIMEM_ADDR   <= '0;
            oINSTR_VALID <= 1'b0;
            oINSTR       <= '0;
        end else begin
            state      <= state_n;
            count_q    <= cnt_n;
            issued     <= issued_n;
            oIMEM_RD   <= rd_n;
            rd_pending <= oIMEM_RD && !abort_req;
            occ        <= occ_n;
            if ((state == IDLE) && iSTART)
                oIMEM_ADDR <= iBASE_ADDR;
            else if (oIMEM_RD)
                oIMEM_ADDR <= oIMEM_ADDR + IBW'(1);
            if (abort_req) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr_n;
                if (push)
                    wr_ptr <= wr_ptr + PTR_ONE;
            end
            oINSTR_VALID <= (occ_n != '0);
            oINSTR       <= head_n;
            oBUSY        <= (state_n == RUN) || (state_n == DRAIN);
            oDONE        <= (state == DONE);
        end
    end

    always_ff @(posedge iACLK) begin
        if (push)
            mem[wr_ptr] <= iIMEM_RDATA;
    end

endmodule
